cv32e40p_permanent_fault_tracker: RTL and testbench

- Watches per-replica disagreement flags from the ALU and MULT TMR voters.
- Counts errors per replica inside a sliding operation window and promotes a replica to permanently faulty once its count reaches a threshold.
- Drives the sticky permanent-fault masks consumed by the faulty-ALU/MULT selection decoder in the EX stage, and raises an interrupt pulse on each new promotion.

---
 rtl/cv32e40p_permanent_fault_tracker_if.sv | 25 ++
 rtl/cv32e40p_permanent_fault_tracker.sv | 95 +++++++++
 tb/tb_cv32e40p_permanent_fault_tracker.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_permanent_fault_tracker_if.sv
// Voter-side bundle of the permanent fault tracker: per-channel op strobes and
// replica mismatch flags in, sticky fault masks, interrupt and debug counters out.
interface cv32e40p_permanent_fault_tracker_if #(
  parameter int unsigned CNT_W = 3
);
  logic                 alu_op_valid_i;
  logic [3:0]           alu_err_i;
  logic                 mult_op_valid_i;
  logic [3:0]           mult_err_i;
  logic                 clear_i;
  logic [3:0]           permanent_faulty_alu_o;
  logic [3:0]           permanent_faulty_mult_o;
  logic                 fault_irq_o;
  logic [4*CNT_W-1:0]   alu_err_cnt_o;

  modport master (
    output alu_op_valid_i, alu_err_i, mult_op_valid_i, mult_err_i, clear_i,
    input  permanent_faulty_alu_o, permanent_faulty_mult_o, fault_irq_o, alu_err_cnt_o
  );

  modport slave (
    input  alu_op_valid_i, alu_err_i, mult_op_valid_i, mult_err_i, clear_i,
    output permanent_faulty_alu_o, permanent_faulty_mult_o, fault_irq_o, alu_err_cnt_o
  );
endinterface

// File: rtl/cv32e40p_permanent_fault_tracker.sv
// Promotes ALU/MULT TMR replicas to permanently faulty once their voter mismatch
// count within a sliding operation window reaches THRESHOLD.
module cv32e40p_permanent_fault_tracker #(
  parameter int unsigned THRESHOLD = 4,
  parameter int unsigned WINDOW    = 256,
  parameter int unsigned CNT_W     = 3
) (
  input  logic clk,
  input  logic rst,
  cv32e40p_permanent_fault_tracker_if.slave bus
);

  localparam int unsigned NREP  = 4;
  localparam int unsigned NCH   = 2;
  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESHOLD);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  // Channel 0 is the ALU, channel 1 the MULT; both are handled identically.
  logic [NCH-1:0]                        valid;
  logic [NCH-1:0][NREP-1:0]              err;
  logic [NCH-1:0][NREP-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NCH-1:0][NREP-1:0]              mask_q, mask_d;
  logic [NCH-1:0][WIN_W-1:0]             win_q, win_d;
  logic                                  irq_q, irq_d;
  logic [CNT_W-1:0]                      inc;

  assign valid = {bus.mult_op_valid_i, bus.alu_op_valid_i};
  assign err   = {bus.mult_err_i, bus.alu_err_i};

  // Next-state: count, promote, then let the window wrap clear the counters.
  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    win_d  = win_q;
    inc    = '0;
    for (int c = 0; c < NCH; c++) begin
      if (valid[c]) begin
        for (int n = 0; n < NREP; n++) begin
          if (err[c][n] && !mask_q[c][n]) begin
            inc = (cnt_q[c][n] == CNT_MAX) ? CNT_MAX : cnt_q[c][n] + CNT_W'(1);
            if (inc >= THR) begin
              mask_d[c][n] = 1'b1;
              cnt_d[c][n]  = '0;
            end else begin
              cnt_d[c][n]  = inc;
            end
          end
        end
        if (win_q[c] == WIN_LAST) begin
          win_d[c] = '0;
          cnt_d[c] = '0;
        end else begin
          win_d[c] = win_q[c] + WIN_W'(1);
        end
      end
    end
    if (bus.clear_i) begin
      cnt_d  = '0;
      mask_d = '0;
      win_d  = '0;
    end
    irq_d = |(mask_d & ~mask_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      mask_q <= '0;
      win_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      win_q  <= win_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.permanent_faulty_alu_o  = mask_q[0];
  assign bus.permanent_faulty_mult_o = mask_q[1];
  assign bus.fault_irq_o             = irq_q;
  assign bus.alu_err_cnt_o           = cnt_q[0];

  // A counter resting at its saturation value means THRESHOLD does not fit CNT_W.
  for (genvar gc = 0; gc < NCH; gc++) begin : g_sat_ch
    for (genvar gn = 0; gn < NREP; gn++) begin : g_sat_rep
      a_no_saturation: assert property (@(posedge clk) disable iff (rst)
        cnt_q[gc][gn] != CNT_MAX);
    end
  end

endmodule

// File: tb/tb_cv32e40p_permanent_fault_tracker.sv
// Bench for the permanent fault tracker: directed scenarios plus randomized
// traffic, all checked against an op-counting reference model.
module tb_cv32e40p_permanent_fault_tracker;

  localparam int unsigned THRESHOLD = 4;
  localparam int unsigned WINDOW    = 256;
  localparam int unsigned CNT_W     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cv32e40p_permanent_fault_tracker_if #(.CNT_W(CNT_W)) ifc ();

  cv32e40p_permanent_fault_tracker #(
    .THRESHOLD (THRESHOLD),
    .WINDOW    (WINDOW),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Reference model: error tallies, fault sets and ops seen in the current window.
  int         m_cnt [2][4];
  logic [3:0] m_mask[2];
  int         m_ops [2];
  logic       m_irq;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int n = 0; n < 4; n++) m_cnt[c][n] = 0;
      m_mask[c] = 4'b0;
      m_ops[c]  = 0;
    end
    m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] prev[2];
    logic       v[2];
    logic [3:0] e[2];
    v[0] = ifc.alu_op_valid_i;  e[0] = ifc.alu_err_i;
    v[1] = ifc.mult_op_valid_i; e[1] = ifc.mult_err_i;
    if (ifc.clear_i) begin
      model_reset();
      return;
    end
    prev[0] = m_mask[0];
    prev[1] = m_mask[1];
    for (int c = 0; c < 2; c++) begin
      if (v[c]) begin
        for (int n = 0; n < 4; n++) begin
          if (e[c][n] && !m_mask[c][n]) begin
            m_cnt[c][n] = m_cnt[c][n] + 1;
            if (m_cnt[c][n] >= THRESHOLD) begin
              m_mask[c][n] = 1'b1;
              m_cnt[c][n]  = 0;
            end
          end
        end
        m_ops[c] = m_ops[c] + 1;
        if (m_ops[c] == WINDOW) begin
          m_ops[c] = 0;
          for (int n = 0; n < 4; n++) m_cnt[c][n] = 0;
        end
      end
    end
    m_irq = ((m_mask[0] & ~prev[0]) | (m_mask[1] & ~prev[1])) != 4'b0;
  endtask

  function automatic logic [20:0] exp_vec();
    logic [4*CNT_W-1:0] packed_cnt;
    packed_cnt = '0;
    for (int n = 0; n < 4; n++) packed_cnt[n*CNT_W +: CNT_W] = CNT_W'(m_cnt[0][n]);
    return {m_mask[0], m_mask[1], m_irq, packed_cnt};
  endfunction

  function automatic logic [20:0] obs();
    return {ifc.permanent_faulty_alu_o, ifc.permanent_faulty_mult_o,
            ifc.fault_irq_o, ifc.alu_err_cnt_o};
  endfunction

  task automatic drive(input logic av, input logic [3:0] ae,
                       input logic mv, input logic [3:0] me, input logic clr);
    ifc.alu_op_valid_i  = av;
    ifc.alu_err_i       = ae;
    ifc.mult_op_valid_i = mv;
    ifc.mult_err_i      = me;
    ifc.clear_i         = clr;
  endtask

  // One clock: the model consumes the current inputs, outputs sampled 1ns after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'b0, 1'b0, 4'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'hF, 1'b1, 4'hF, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    ntests++;
    if (obs() !== 21'h0) begin
      nfail++; $display("FAIL reset_hold got %h exp %h", obs(), 21'h0);
    end
    do_reset();
    ntests++;
    if (obs() !== exp_vec()) begin
      nfail++; $display("FAIL reset_release got %h exp %h", obs(), exp_vec());
    end
  endtask

  task automatic test_clean_window();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'b0, 1'b0, 4'b0, 1'b0);
      cycle();
      ntests++;
      if (obs() !== exp_vec()) begin
        nfail++; $display("FAIL clean_op%0d got %h exp %h", i + 1, obs(), exp_vec());
      end
    end
    ntests++;
    if (ifc.permanent_faulty_alu_o !== 4'b0000 || ifc.fault_irq_o !== 1'b0) begin
      nfail++; $display("FAIL clean_final got mask=%b irq=%b exp mask=0000 irq=0",
                        ifc.permanent_faulty_alu_o, ifc.fault_irq_o);
    end
  endtask

  task automatic test_single_promotion();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b0010, 1'b0, 4'b0, 1'b0);
      cycle();
      ntests++;
      if (obs() !== exp_vec()) begin
        nfail++; $display("FAIL promo_op%0d got %h exp %h", i + 1, obs(), exp_vec());
      end
      if (i == 2) begin
        ntests++;
        if (ifc.alu_err_cnt_o[5:3] !== 3'd3 || ifc.permanent_faulty_alu_o !== 4'b0) begin
          nfail++; $display("FAIL promo_pre cnt1=%0d mask=%b exp cnt1=3 mask=0000",
                            ifc.alu_err_cnt_o[5:3], ifc.permanent_faulty_alu_o);
        end
      end
    end
    ntests++;
    if (ifc.permanent_faulty_alu_o !== 4'b0010 || ifc.fault_irq_o !== 1'b1 ||
        ifc.alu_err_cnt_o[5:3] !== 3'd0) begin
      nfail++; $display("FAIL promo_set mask=%b irq=%b cnt1=%0d exp mask=0010 irq=1 cnt1=0",
                        ifc.permanent_faulty_alu_o, ifc.fault_irq_o, ifc.alu_err_cnt_o[5:3]);
    end
    drive(1'b0, 4'b0, 1'b0, 4'b0, 1'b0);
    cycle();
    ntests++;
    if (ifc.fault_irq_o !== 1'b0 || ifc.permanent_faulty_alu_o !== 4'b0010) begin
      nfail++; $display("FAIL promo_after irq=%b mask=%b exp irq=0 mask=0010",
                        ifc.fault_irq_o, ifc.permanent_faulty_alu_o);
    end
  endtask

  task automatic test_window_clear();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0100, 1'b0, 4'b0, 1'b0);
      cycle();
    end
    ntests++;
    if (ifc.alu_err_cnt_o[8:6] !== 3'd3) begin
      nfail++; $display("FAIL win_pre cnt2=%0d exp 3", ifc.alu_err_cnt_o[8:6]);
    end
    for (int i = 0; i < WINDOW - 3; i++) begin
      drive(1'b1, 4'b0, 1'b0, 4'b0, 1'b0);
      cycle();
      ntests++;
      if (obs() !== exp_vec()) begin
        nfail++; $display("FAIL win_clean%0d got %h exp %h", i, obs(), exp_vec());
      end
    end
    ntests++;
    if (ifc.alu_err_cnt_o[8:6] !== 3'd0) begin
      nfail++; $display("FAIL win_wrap cnt2=%0d exp 0", ifc.alu_err_cnt_o[8:6]);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0100, 1'b0, 4'b0, 1'b0);
      cycle();
    end
    ntests++;
    if (ifc.alu_err_cnt_o[8:6] !== 3'd3 || ifc.permanent_faulty_alu_o !== 4'b0 ||
        obs() !== exp_vec()) begin
      nfail++; $display("FAIL win_post cnt2=%0d mask=%b exp cnt2=3 mask=0000",
                        ifc.alu_err_cnt_o[8:6], ifc.permanent_faulty_alu_o);
    end
  endtask

  task automatic test_last_op_promotion();
    do_reset();
    for (int i = 0; i < WINDOW - 4; i++) begin
      drive(1'b1, 4'b0, 1'b0, 4'b0, 1'b0);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0001, 1'b0, 4'b0, 1'b0);
      cycle();
    end
    ntests++;
    if (ifc.alu_err_cnt_o[2:0] !== 3'd3 || obs() !== exp_vec()) begin
      nfail++; $display("FAIL last_pre cnt0=%0d got %h exp %h",
                        ifc.alu_err_cnt_o[2:0], obs(), exp_vec());
    end
    drive(1'b1, 4'b0001, 1'b0, 4'b0, 1'b0);
    cycle();
    ntests++;
    if (ifc.permanent_faulty_alu_o !== 4'b0001 || ifc.fault_irq_o !== 1'b1 ||
        ifc.alu_err_cnt_o !== 12'h0) begin
      nfail++; $display("FAIL last_promo mask=%b irq=%b cnt=%h exp mask=0001 irq=1 cnt=000",
                        ifc.permanent_faulty_alu_o, ifc.fault_irq_o, ifc.alu_err_cnt_o);
    end
  endtask

  task automatic test_dual_channel();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b1000, 1'b1, 4'b0110, 1'b0);
      cycle();
      if (ifc.fault_irq_o === 1'b1) pulses++;
    end
    ntests++;
    if (ifc.permanent_faulty_alu_o !== 4'b1000 || ifc.permanent_faulty_mult_o !== 4'b0110 ||
        ifc.fault_irq_o !== 1'b1) begin
      nfail++; $display("FAIL dual_set alu=%b mult=%b irq=%b exp alu=1000 mult=0110 irq=1",
                        ifc.permanent_faulty_alu_o, ifc.permanent_faulty_mult_o, ifc.fault_irq_o);
    end
    drive(1'b1, 4'hF, 1'b1, 4'hF, 1'b1);
    cycle();
    if (ifc.fault_irq_o === 1'b1) pulses++;
    ntests++;
    if (obs() !== 21'h0 || obs() !== exp_vec()) begin
      nfail++; $display("FAIL dual_clear got %h exp %h", obs(), 21'h0);
    end
    ntests++;
    if (pulses != 1) begin
      nfail++; $display("FAIL dual_irq_pulses got %0d exp 1", pulses);
    end
  endtask

  task automatic test_faulty_ignored_and_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b1000, 1'b0, 4'b0, 1'b0);
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b1000, 1'b0, 4'b0, 1'b0);
      cycle();
      ntests++;
      if (ifc.alu_err_cnt_o[11:9] !== 3'd0 || ifc.fault_irq_o !== 1'b0 ||
          ifc.permanent_faulty_alu_o !== 4'b1000) begin
        nfail++; $display("FAIL faulty_ignore%0d cnt3=%0d irq=%b mask=%b exp cnt3=0 irq=0 mask=1000",
                          i, ifc.alu_err_cnt_o[11:9], ifc.fault_irq_o, ifc.permanent_faulty_alu_o);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'hF, 1'b0, 4'hF, 1'b0);
      cycle();
      ntests++;
      if (obs() !== exp_vec()) begin
        nfail++; $display("FAIL invalid_ignore%0d got %h exp %h", i, obs(), exp_vec());
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b0010, 1'b0, 4'b0, 1'b0);
      cycle();
    end
    ntests++;
    if (ifc.alu_err_cnt_o[5:3] !== 3'd2 || obs() !== exp_vec()) begin
      nfail++; $display("FAIL mid_window got %h exp %h", obs(), exp_vec());
    end
    drive(1'b0, 4'b0, 1'b0, 4'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    ntests++;
    if (obs() !== 21'h0) begin
      nfail++; $display("FAIL async_reset got %h exp %h", obs(), 21'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic       av, mv, clr;
    logic [3:0] ae, me;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      av  = ($urandom_range(0, 3) != 0);
      mv  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 299) == 0);
      for (int n = 0; n < 4; n++) begin
        ae[n] = ($urandom_range(0, 5) == 0);
        me[n] = ($urandom_range(0, 5) == 0);
      end
      drive(av, ae, mv, me, clr);
      cycle();
      ntests++;
      if (obs() !== exp_vec()) begin
        nfail++; $display("FAIL random_cyc%0d got %h exp %h", i, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    drive(1'b0, 4'b0, 1'b0, 4'b0, 1'b0);
    model_reset();
    test_reset();
    test_clean_window();
    test_single_promotion();
    test_window_clear();
    test_last_op_promotion();
    test_dual_channel();
    test_faulty_ignored_and_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
